psg_env_sched: RTL
==================

Name: psg_env_sched

Overview:
Volume-envelope scheduler in front of the 16-voice PSG attribute write port. On each sample tick it steps every enabled channel's volume one unit toward a programmed target at a programmed rate. It writes the changed volume byte into PSG attribute RAM, sharing that single write port with CPU attribute writes (CPU has priority). It keeps a shadow of each channel's byte 2 ({right_en, left_en, volume}) so envelope writes never corrupt the pan bits.

Parameters:
NUM_CH, 16, number of PSG channels (fixed by the 6-bit attribute address: 4-bit channel, 2-bit byte).
RATE_W, 8, width of the per-channel rate divider.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_attr_addr  in  6  CPU attribute address {ch[3:0], byte[1:0]}
cpu_attr_wrdata  in  8  CPU attribute write data
cpu_attr_write  in  1  CPU attribute write strobe, one cycle per write
env_addr  in  5  envelope config address {ch[3:0], sel}
env_wrdata  in  8  config data: sel=0 -> rate[7:0]; sel=1 -> {en, 1'b0, target[5:0]}
env_write  in  1  envelope config write strobe
next_sample  in  1  sample tick, single-cycle pulse
psg_attr_addr  out  6  to PSG attr_addr
psg_attr_wrdata  out  8  to PSG attr_wrdata
psg_attr_write  out  1  to PSG attr_write
busy  out  1  high while a scan is in progress
overrun  out  1  sticky; set when next_sample arrives while busy

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; per-channel shadow byte2, rate, target, en, and divider all 0; overrun cleared. Only reset clears overrun.
- Output port: registered, 1-cycle latency. cpu_attr_write in cycle N drives psg_attr_* in cycle N+1 with identical addr/data.
- Shadow snoop: a CPU write with byte==2 loads shadow[ch] <= wrdata in the same cycle. A CPU write to any other byte does not affect the shadow.
- Config writes:
  - sel=0 loads rate[ch].
  - sel=1 loads en[ch] and target[ch], and clears div[ch].
  - Config writes never touch the PSG port.
- FSM states: IDLE, STEP, WRITE. ch is a 4-bit index.
  - IDLE: busy=0. next_sample -> ch=0, go to STEP.
  - STEP (1 cycle per channel):
    - en[ch]=0 -> advance.
    - en[ch]=1 and div[ch]!=rate[ch] -> div[ch]+=1, advance.
    - en[ch]=1 and div[ch]==rate[ch] -> div[ch]=0, then:
      - vol=shadow[ch][5:0]; vol<target -> vol+1; vol>target -> vol-1; equal -> advance, no write.
      - On change, latch new byte {shadow[7:6], vol'} and go to WRITE.
  - WRITE:
    - No cpu_attr_write this cycle -> emit addr {ch,2'b10} with the latched byte next cycle, update shadow[ch], advance.
    - cpu_attr_write present -> the CPU access is forwarded and WRITE holds (retries next cycle).
    - CPU write to {ch,2'b10} while in WRITE -> the pending envelope write is dropped (CPU value wins, shadow takes CPU data), advance.
  - advance: ch==NUM_CH-1 -> IDLE; else ch+=1 and go to STEP.
- rate=0 steps every tick; rate=R steps every R+1 ticks. Volume saturates at target; there is no wrap.
- busy=1 in STEP and WRITE.
- next_sample while busy: ignored, overrun<=1.
- Simultaneous cpu_attr_write and env_write are independent; both are accepted.
- Worst-case scan length is 32 cycles plus CPU stall cycles.
- Reset mid-scan: aborts immediately to IDLE with no partial write emitted.

Test Plan:
- CPU write addr 0x06 data 0xC0, no envelope active -> psg_attr_addr=0x06, wrdata=0xC0, write=1 exactly one cycle later; shadow[1]=0xC0.
- ch1 shadow 0xC0, config rate=0 target=3 en=1, then 4 ticks -> writes 0xC1, 0xC2, 0xC3 to addr 0x06 on ticks 1-3; no write on tick 4.
- ch0 shadow 0x7F (pan 01, vol 63), rate=2 target=60, 9 ticks -> writes 0x7E, 0x7D, 0x7C on ticks 3, 6, 9; pan bits stay 01.
- Envelope in WRITE for ch2 while CPU writes addr 0x0A data 0x85 -> only 0x85 is emitted; the envelope write is dropped; next step starts from vol 5.
- Envelope in WRITE for ch3 while CPU writes addr 0x00 -> CPU write forwarded first, envelope write to 0x0E follows one cycle later.
- next_sample pulsed twice 3 cycles apart -> overrun=1 and stays 1; rst_n low mid-scan -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/psg_env_sched.sv
// Volume-envelope scheduler feeding the PSG attribute write port.
// Steps each enabled channel's volume toward its target once per sample scan.
module psg_env_sched #(
    parameter int NUM_CH = 16,
    parameter int RATE_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] cpu_attr_addr,
    input  logic [7:0] cpu_attr_wrdata,
    input  logic       cpu_attr_write,
    input  logic [4:0] env_addr,
    input  logic [7:0] env_wrdata,
    input  logic       env_write,
    input  logic       next_sample,
    output logic [5:0] psg_attr_addr,
    output logic [7:0] psg_attr_wrdata,
    output logic       psg_attr_write,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, STEP, WRITE} state_t;

    state_t state, state_nx;
    logic [3:0] ch, ch_nx;

    logic [7:0]        shadow [NUM_CH];
    logic [RATE_W-1:0] rate   [NUM_CH];
    logic [RATE_W-1:0] div    [NUM_CH];
    logic [5:0]        target [NUM_CH];
    logic [NUM_CH-1:0] en;
    logic [7:0]        pend;

    logic [3:0] cpu_ch, env_ch;
    logic       cpu_b2;
    logic [7:0] cur_sh;
    logic [5:0] cur_vol, cur_tgt, vol_nx;
    logic       div_hit;
    logic       advance, div_inc, div_clr, latch, emit;
    logic       unused_cfg;

    assign cpu_ch     = cpu_attr_addr[5:2];
    assign cpu_b2     = (cpu_attr_addr[1:0] == 2'b10);
    assign env_ch     = env_addr[4:1];
    assign cur_sh     = shadow[ch];
    assign cur_vol    = cur_sh[5:0];
    assign cur_tgt    = target[ch];
    assign div_hit    = (div[ch] == rate[ch]);
    assign vol_nx     = (cur_vol < cur_tgt) ? cur_vol + 6'd1 : cur_vol - 6'd1;
    assign unused_cfg = env_wrdata[6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch    <= '0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        busy     = 1'b0;
        advance  = 1'b0;
        div_inc  = 1'b0;
        div_clr  = 1'b0;
        latch    = 1'b0;
        emit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (next_sample) begin
                    state_nx = STEP;
                    ch_nx    = '0;
                end
            end
            STEP: begin
                busy = 1'b1;
                if (!en[ch]) begin
                    advance = 1'b1;
                end else if (!div_hit) begin
                    div_inc = 1'b1;
                    advance = 1'b1;
                end else begin
                    div_clr = 1'b1;
                    if (cur_vol == cur_tgt) begin
                        advance = 1'b1;
                    end else begin
                        latch    = 1'b1;
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                busy = 1'b1;
                // CPU owns the port; a CPU hit on this byte supersedes our write
                if (!cpu_attr_write) begin
                    emit    = 1'b1;
                    advance = 1'b1;
                end else if (cpu_attr_addr == {ch, 2'b10}) begin
                    advance = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (advance) begin
            if (ch == 4'(NUM_CH - 1)) begin
                state_nx = IDLE;
            end else begin
                ch_nx    = ch + 4'd1;
                state_nx = STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                rate[i]   <= '0;
                div[i]    <= '0;
                target[i] <= '0;
            end
            en              <= '0;
            pend            <= '0;
            psg_attr_addr   <= '0;
            psg_attr_wrdata <= '0;
            psg_attr_write  <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            if (div_inc)
                div[ch] <= div[ch] + RATE_W'(1);
            if (div_clr)
                div[ch] <= '0;
            if (latch)
                pend <= {cur_sh[7:6], vol_nx};
            if (emit)
                shadow[ch] <= pend;
            if (cpu_attr_write && cpu_b2)
                shadow[cpu_ch] <= cpu_attr_wrdata;
            // Config write after scan update so a rewrite wins the divider
            if (env_write) begin
                if (!env_addr[0]) begin
                    rate[env_ch] <= RATE_W'(env_wrdata);
                end else begin
                    en[env_ch]     <= env_wrdata[7];
                    target[env_ch] <= env_wrdata[5:0];
                    div[env_ch]    <= '0;
                end
            end
            if (cpu_attr_write) begin
                psg_attr_addr   <= cpu_attr_addr;
                psg_attr_wrdata <= cpu_attr_wrdata;
                psg_attr_write  <= 1'b1;
            end else if (emit) begin
                psg_attr_addr   <= {ch, 2'b10};
                psg_attr_wrdata <= pend;
                psg_attr_write  <= 1'b1;
            end else begin
                psg_attr_write  <= 1'b0;
            end
            if (next_sample && state != IDLE)
                overrun <= 1'b1;
        end
    end

endmodule
